ysyx_25030081_ctrl: RTL and testbench
=====================================

Name: ysyx_25030081_ctrl

Overview:
- Multi-cycle sequencer for the NPC core. Drives one instruction through fetch, decode, execute, memory and writeback at a time.
- Owns the PC and the instruction register (IR). Feeds the IR to the field decoder and takes opcode/funct3 back from it.
- Handshakes with instruction and data memory. Issues one-cycle enables to the EXU and the register file.
- Halts on ebreak, an illegal opcode or a misaligned next-PC.

Parameters:
- DATA_WIDTH, 32, width of PC, IR and memory data/addresses
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- pc_o  out  DATA_WIDTH  current PC
- ir_o  out  DATA_WIDTH  latched instruction, to decoder
- opcode_i  in  7  opcode from decoder
- funct3_i  in  3  funct3 from decoder
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  fetch request accepted
- imem_req_addr  out  DATA_WIDTH  fetch address, equals pc_o
- imem_rsp_valid  in  1  fetch data valid
- imem_rsp_data  in  DATA_WIDTH  fetched instruction
- dmem_req_valid  out  1  data request valid
- dmem_req_ready  in  1  data request accepted
- dmem_req_we  out  1  1 = store, 0 = load
- dmem_rsp_valid  in  1  load data / store ack
- exec_en  out  1  one-cycle EXU enable
- rf_we  out  1  one-cycle register-file write enable
- pc_next_i  in  DATA_WIDTH  next PC from EXU, valid in WB
- halt  out  1  sticky: core stopped
- illegal  out  1  sticky: halt cause was not ebreak
- retired  out  CNT_WIDTH  count of instructions that completed WB

Behaviour:
- States: IDLE, FETCH, WAIT_I, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT. All control outputs decode from the registered state only (Moore).
- Reset (rst=1 at posedge) has priority over everything, including mid-operation:
  - state=IDLE, pc=RESET_PC, ir=0, retired=0, halt=0, illegal=0.
  - Any outstanding request is abandoned. Memory models must be reset together with the core.
- IDLE -> FETCH unconditionally. All valids and enables are 0 in IDLE.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc.
  - Valid is held until imem_req_ready=1, then -> WAIT_I. Never withdrawn.
  - imem_rsp_valid in FETCH is ignored.
- WAIT_I: on imem_rsp_valid, ir<=imem_rsp_data and -> DECODE. Otherwise wait indefinitely.
- DECODE (one cycle), using opcode_i:
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011 -> EXEC.
  - SYSTEM 1110011 with funct3_i=0 and ir[31:20]=1 (ebreak) -> HALT, illegal=0.
  - Any other SYSTEM form or opcode -> HALT, illegal=1.
- EXEC:
  - exec_en=1 for exactly this cycle.
  - LOAD/STORE -> MEM_REQ. All other legal opcodes -> WB.
- MEM_REQ:
  - dmem_req_valid=1, dmem_req_we=1 iff opcode is STORE.
  - Held until dmem_req_ready, then -> MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid -> WB.
- WB:
  - rf_we=1 unless opcode is STORE or BRANCH.
  - If pc_next_i[1:0]!=0: -> HALT, illegal=1, pc unchanged, rf_we still 0 (the writeback is suppressed) and retired not incremented.
  - Otherwise: pc<=pc_next_i, retired<=retired+1 (wraps modulo 2^CNT_WIDTH), -> FETCH.
- HALT: absorbing until reset. halt=1 and all valids and enables are 0.
- Latency with ready=1 and a response one cycle after acceptance:
  - non-memory instruction: 5 cycles FETCH-to-FETCH;
  - load/store: 7 cycles.

Decomposition:
- Shared package ysyx_25030081_pkg: state enum, the opcode constants, EBREAK_IMM=12'h001.
- One combinational sub-module ysyx_25030081_opclass:
  - input: opcode, funct3, ir[31:20];
  - outputs: is_legal, is_ebreak, is_load, is_store, writes_rd.
- FSM, PC, IR and counter stay in ctrl.

Test Plan:
- Reset then ADDI 0x00100093 at 0x80000000, ready=1, rsp +1 cycle, pc_next=0x80000004 -> imem_req_valid first asserted 1 cycle after reset release, exec_en and rf_we each pulse once, pc_o=0x80000004 after 5 cycles, retired=1.
- LW 0x0000a103, dmem_req_ready held 0 for 3 cycles -> dmem_req_valid stays 1 with we=0 throughout, rf_we pulses once after dmem_rsp_valid.
- SW 0x0020a023 -> dmem_req_we=1, rf_we never asserted, retired increments.
- ebreak 0x00100073 -> halt=1, illegal=0, no exec_en. Ecall 0x00000073 or opcode 0x7F -> halt=1, illegal=1. No further imem_req_valid over 20 cycles.
- JAL with pc_next_i=0x80000002 -> halt=1, illegal=1, pc_o unchanged, rf_we never asserted, retired not incremented.
- rst pulsed during MEM_WAIT -> next cycle state IDLE, pc_o=0x80000000, retired=0, all valids 0. A late dmem_rsp_valid is ignored.

Source files
------------

// File: rtl/ysyx_25030081_pkg.sv
// Shared definitions for the NPC multi-cycle sequencer: FSM states and
// the RV32I major-opcode constants that the control path distinguishes.
package ysyx_25030081_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_I,
        S_DECODE,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ebreak is SYSTEM / funct3=PRIV / imm=1; ecall shares everything but imm
    localparam logic [2:0]  F3_PRIV    = 3'b000;
    localparam logic [11:0] EBREAK_IMM = 12'h001;

endpackage

// File: rtl/ysyx_25030081_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory side (slave).
interface ysyx_25030081_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;

    logic                  dmem_req_valid;
    logic                  dmem_req_ready;
    logic                  dmem_req_we;
    logic                  dmem_rsp_valid;

    modport master (
        output imem_req_valid, imem_req_addr, dmem_req_valid, dmem_req_we,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               dmem_req_ready, dmem_rsp_valid
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dmem_req_valid, dmem_req_we,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               dmem_req_ready, dmem_rsp_valid
    );
endinterface

// File: rtl/ysyx_25030081_opclass.sv
// Combinational instruction classifier: turns the decoder's opcode/funct3
// plus the I-immediate field into the few facts the sequencer acts on.
module ysyx_25030081_opclass
    import ysyx_25030081_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [11:0] i_imm,
    output logic        o_is_legal,
    output logic        o_is_ebreak,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_writes_rd
);

    // Legal opcodes, and which of them produce a destination register value
    always_comb begin
        o_is_legal  = 1'b0;
        o_writes_rd = 1'b0;
        case (i_opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: begin
                o_is_legal  = 1'b1;
                o_writes_rd = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                o_is_legal  = 1'b1;
            end
            default: ;
        endcase
    end

    // SYSTEM is never "legal" here; only the exact ebreak form halts cleanly
    assign o_is_ebreak = (i_opcode == OP_SYSTEM) && (i_funct3 == F3_PRIV) &&
                         (i_imm == EBREAK_IMM);
    assign o_is_load   = (i_opcode == OP_LOAD);
    assign o_is_store  = (i_opcode == OP_STORE);

endmodule

// File: rtl/ysyx_25030081_ctrl.sv
// NPC multi-cycle sequencer: one instruction at a time through
// fetch / decode / execute / memory / writeback. Owns PC, IR and the
// retired-instruction counter; all handshake outputs are Moore outputs.
module ysyx_25030081_ctrl
    import ysyx_25030081_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_25030081_ctrl_if.master  mem,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ir_o,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] pc_next_i,
    output logic                  exec_en,
    output logic                  rf_we,
    output logic                  halt,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [CNT_WIDTH-1:0]  r_retired;
    logic                  r_illegal;

    logic w_is_legal;
    logic w_is_ebreak;
    logic w_is_load;
    logic w_is_store;
    logic w_writes_rd;
    logic w_misalign;
    logic w_ir_load;
    logic w_pc_load;
    logic w_set_illegal;

    ysyx_25030081_opclass u_opclass (
        .i_opcode    (opcode_i),
        .i_funct3    (funct3_i),
        .i_imm       (r_ir[31:20]),
        .o_is_legal  (w_is_legal),
        .o_is_ebreak (w_is_ebreak),
        .o_is_load   (w_is_load),
        .o_is_store  (w_is_store),
        .o_writes_rd (w_writes_rd)
    );

    // A next-PC that is not word aligned cannot be fetched; catch it in WB
    assign w_misalign = (pc_next_i[1:0] != 2'b00);

    // Next-state logic and state-decoded control outputs
    always_comb begin
        w_state_nxt        = r_state;
        w_ir_load          = 1'b0;
        w_pc_load          = 1'b0;
        w_set_illegal      = 1'b0;
        mem.imem_req_valid = 1'b0;
        mem.dmem_req_valid = 1'b0;
        mem.dmem_req_we    = 1'b0;
        exec_en            = 1'b0;
        rf_we              = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // a response arriving here is stale and deliberately ignored
                mem.imem_req_valid = 1'b1;
                if (mem.imem_req_ready) w_state_nxt = S_WAIT_I;
            end
            S_WAIT_I: begin
                if (mem.imem_rsp_valid) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt   = S_HALT;
                    w_set_illegal = !w_is_ebreak;
                end
            end
            S_EXEC: begin
                exec_en     = 1'b1;
                w_state_nxt = (w_is_load || w_is_store) ? S_MEM_REQ : S_WB;
            end
            S_MEM_REQ: begin
                mem.dmem_req_valid = 1'b1;
                mem.dmem_req_we    = w_is_store;
                if (mem.dmem_req_ready) w_state_nxt = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem.dmem_rsp_valid) w_state_nxt = S_WB;
            end
            S_WB: begin
                // a bad next-PC aborts the instruction: no RF write, no retire
                if (w_misalign) begin
                    w_state_nxt   = S_HALT;
                    w_set_illegal = 1'b1;
                end else begin
                    rf_we       = w_writes_rd;
                    w_pc_load   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: ;
            default: w_state_nxt = S_HALT;
        endcase
    end

    // State, PC, IR, retire counter and sticky cause; reset overrides all
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ir_load) r_ir <= mem.imem_rsp_data;
            if (w_pc_load) begin
                r_pc      <= pc_next_i;
                r_retired <= r_retired + CNT_ONE;
            end
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    assign mem.imem_req_addr = r_pc;
    assign pc_o              = r_pc;
    assign ir_o              = r_ir;
    assign retired           = r_retired;
    assign illegal           = r_illegal;
    assign halt              = (r_state == S_HALT);

endmodule

// File: tb/tb_ysyx_25030081_ctrl.sv
// Bench for the NPC sequencer: directed cases then random instructions with
// random handshake delays, each checked against a transaction-level model.
module tb_ysyx_25030081_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_o, ir_o, pc_next_i, retired;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic        exec_en, rf_we, halt, illegal;

    ysyx_25030081_ctrl_if #(.DATA_WIDTH(32)) bus ();

    ysyx_25030081_ctrl #(
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC),
        .CNT_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus),
        .pc_o      (pc_o),
        .ir_o      (ir_o),
        .opcode_i  (opcode_i),
        .funct3_i  (funct3_i),
        .pc_next_i (pc_next_i),
        .exec_en   (exec_en),
        .rf_we     (rf_we),
        .halt      (halt),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // field decoder stand-in
    assign opcode_i = ir_o[6:0];
    assign funct3_i = ir_o[14:12];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
    endtask

    // What the ISA rules say the instruction should do
    function automatic void ref_cls(input logic [31:0] ins, output bit legal,
                                    output bit ebk, output bit memop,
                                    output bit st, output bit wr);
        logic [6:0] op;
        op    = ins[6:0];
        legal = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        ebk   = (op == 7'h73) && (ins[14:12] == 3'd0) && (ins[31:20] == 12'h001);
        memop = (op == 7'h03) || (op == 7'h23);
        st    = (op == 7'h23);
        wr    = legal && (op != 7'h23) && (op != 7'h63);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_ir", ir_o, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_flags", {29'd0, halt, illegal, bus.imem_req_valid}, 32'd0);
        rst = 1'b0;
        tick();
        chk("fetch_after_rst", 32'(bus.imem_req_valid), 32'd1);
        m_pc  = RST_PC;
        m_ret = '0;
    endtask

    // Drive one instruction through the DUT as the memories would, starting
    // at a negedge where the DUT is (or is about to be) fetching.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] pnx,
                             input int ri, input int si, input int rd, input int sd,
                             input bit rst_mid, output bit halted);
        bit legal, ebk, memop, st, wr, adv, exp_halt, exp_ill;
        bit iseen, iacc, dseen, dacc, done, aborted;
        int n_ex, n_rf, t0, lat, icnt, dcnt, iwait, dwait, n_idrop, n_ddrop, n_dx;
        ref_cls(ins, legal, ebk, memop, st, wr);
        adv      = legal && (pnx[1:0] == 2'b00);
        exp_halt = !adv;
        exp_ill  = exp_halt && !ebk;
        {iseen, iacc, dseen, dacc, done, aborted} = '0;
        {n_ex, n_rf, icnt, dcnt, n_idrop, n_ddrop, n_dx} = '0;
        t0 = 0; lat = -1; iwait = -1; dwait = -1;
        pc_next_i = pnx;
        for (int c = 0; c < 300 && !done; c++) begin
            if (exec_en) n_ex++;
            if (rf_we)   n_rf++;
            idle_inputs();
            if (halt) begin
                done = 1'b1;
            end else if (!iacc) begin
                if (bus.imem_req_valid) begin
                    if (!iseen) begin
                        iseen = 1'b1;
                        t0    = c;
                        chk("fetch_addr", bus.imem_req_addr, m_pc);
                    end
                    // a stale response during the request phase must be ignored
                    bus.imem_rsp_valid = 1'($urandom_range(0, 1));
                    bus.imem_rsp_data  = 32'hFFFF_FFFF;
                    if (icnt == ri) begin
                        bus.imem_req_ready = 1'b1;
                        iacc  = 1'b1;
                        iwait = si;
                    end else begin
                        icnt++;
                    end
                end else if (iseen) begin
                    n_idrop++;
                end
            end else if (bus.imem_req_valid) begin
                lat  = c - t0;
                done = 1'b1;
            end else begin
                if (iwait == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = ins;
                end
                if (iwait >= 0) iwait--;
                if (bus.dmem_req_valid) begin
                    chk("dmem_we", 32'(bus.dmem_req_we), 32'(st));
                    if (dacc) begin
                        n_dx++;
                    end else begin
                        dseen = 1'b1;
                        if (dcnt == rd) begin
                            bus.dmem_req_ready = 1'b1;
                            dacc  = 1'b1;
                            dwait = sd;
                        end else begin
                            dcnt++;
                        end
                    end
                end else if (dseen && !dacc) begin
                    n_ddrop++;
                end else if (dacc && rst_mid) begin
                    // waiting for the data response: reset the core here
                    rst = 1'b1;
                    tick();
                    chk("midrst_pc", pc_o, RST_PC);
                    chk("midrst_retired", retired, 32'd0);
                    chk("midrst_quiet", {27'd0, bus.imem_req_valid, bus.dmem_req_valid,
                                         exec_en, rf_we, halt}, 32'd0);
                    rst = 1'b0;
                    bus.dmem_rsp_valid = 1'b1;   // late response
                    tick();
                    bus.dmem_rsp_valid = 1'b0;
                    chk("midrst_refetch", {29'd0, bus.imem_req_valid, bus.dmem_req_valid,
                                           exec_en}, 32'd4);
                    m_pc    = RST_PC;
                    m_ret   = '0;
                    aborted = 1'b1;
                    done    = 1'b1;
                end else if (dacc) begin
                    if (dwait == 0) bus.dmem_rsp_valid = 1'b1;
                    if (dwait >= 0) dwait--;
                end
            end
            if (!done) tick();
        end
        halted = exp_halt;
        chk("no_timeout", 32'(done), 32'd1);
        if (!aborted) begin
            chk("ir", ir_o, ins);
            chk("exec_pulses", n_ex, 32'(legal));
            chk("rf_we_pulses", n_rf, 32'(wr && adv));
            chk("dmem_used", 32'(dacc), 32'(memop));
            chk("handshake_held", n_idrop + n_ddrop + n_dx, 32'd0);
            chk("halt", 32'(halt), 32'(exp_halt));
            chk("illegal", 32'(illegal), 32'(exp_ill));
            if (adv) begin
                m_pc  = pnx;
                m_ret = m_ret + 32'd1;
                chk("latency", lat, 5 + ri + si + (memop ? 2 + rd + sd : 0));
            end
            chk("pc", pc_o, m_pc);
            chk("retired", retired, m_ret);
            if (exp_halt) begin
                for (int k = 0; k < 20; k++) begin
                    tick();
                    chk("halt_quiet", {27'd0, bus.imem_req_valid, bus.dmem_req_valid,
                                       exec_en, rf_we, !halt}, 32'd0);
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [0:8];
        logic [31:0] r;
        int          pick;
        ops  = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        r    = $urandom;
        pick = int'($urandom_range(0, 23));
        if (pick < 20)       rand_ins = {r[31:7], ops[r % 9]};
        else if (pick == 20) rand_ins = 32'h0010_0073;
        else if (pick == 21) rand_ins = {r[31:7], 7'h73};
        else if (pick == 22) rand_ins = 32'h0000_0073;
        else                 rand_ins = {r[31:7], 7'h7F};
    endfunction

    initial begin
        bit          h;
        logic [31:0] ins, pnx;
        rst       = 1'b1;
        pc_next_i = '0;
        idle_inputs();
        do_reset();

        run_instr(32'h0010_0093, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, h);   // addi
        run_instr(32'h0000_a103, m_pc + 32'd4, 0, 0, 3, 0, 1'b0, h);   // lw, slow ready
        run_instr(32'h0020_a023, m_pc + 32'd4, 1, 2, 0, 1, 1'b0, h);   // sw
        run_instr(32'h0000_8463, m_pc + 32'd8, 0, 0, 0, 0, 1'b0, h);   // beq taken
        run_instr(32'h0010_0073, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, h);   // ebreak
        do_reset();
        run_instr(32'h0000_0073, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, h);   // ecall
        do_reset();
        run_instr(32'h0000_007F, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, h);   // bad opcode
        do_reset();
        run_instr(32'h0080_00EF, 32'h8000_0002, 0, 0, 0, 0, 1'b0, h);  // jal misaligned
        do_reset();
        run_instr(32'h0010_0093, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, h);
        run_instr(32'h0000_a103, m_pc + 32'd4, 0, 0, 1, 2, 1'b1, h);   // reset in MEM_WAIT
        run_instr(32'h0010_0093, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, h);

        for (int i = 0; i < 80; i++) begin
            ins = rand_ins();
            case ($urandom_range(0, 11))
                0:       pnx = m_pc + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                1, 2:    pnx = {$urandom, 2'b00} >> 2 << 2;
                default: pnx = m_pc + 32'd4;
            endcase
            run_instr(ins, pnx, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, h);
            if (h) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
